// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 keyboard command/response bytes, sequencer states and retry-target helper
package ps2_pkg;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR   = 8'hFC;
  typedef enum logic [3:0] {
    INIT_SEND, INIT_ACK, INIT_BAT, READY, CMD_SEND, CMD_ACK, ARG_SEND, ARG_ACK, FAIL
  } state_t;
  function automatic state_t send_of(input state_t s);
    return s inside {CMD_SEND, CMD_ACK} ? CMD_SEND : s inside {ARG_SEND, ARG_ACK} ? ARG_SEND : INIT_SEND;
  endfunction
endpackage

// File: rtl/ps2_timeout_counter.sv
// ps2_timeout_counter: down-counter (clk, reset, load/load_value, en) raising expired when it hits zero
module ps2_timeout_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (en && !expired) count <= count - 1'b1;
  assign expired = count == '0;
endmodule

// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer: keyboard init + LED/typematic command FSM; requests in, command/handshake to PS/2 core, scan bytes and status out
module ps2_command_sequencer
  import ps2_pkg::*;
#(
  parameter int RESP_TIMEOUT_CYCLES = 2_500_000,
  parameter int BAT_TIMEOUT_CYCLES  = 50_000_000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic       led_update,
  input  logic [2:0] led_state,
  input  logic       typematic_update,
  input  logic [7:0] typematic_rate,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       command_error,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] scan_data,
  output logic       scan_valid,
  output logic       busy,
  output logic       kbd_ready,
  output logic       error
);
  localparam int TW = $clog2(BAT_TIMEOUT_CYCLES + 1);
  localparam int RW = MAX_RETRIES < 1 ? 1 : $clog2(MAX_RETRIES + 1);
  state_t state, state_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic init_req, init_req_n, led_pend, led_pend_n, typ_pend, typ_pend_n;
  logic [2:0] led_val, led_val_n;
  logic [7:0] typ_val, typ_val_n, cur_cmd, cmd_n, cur_arg, arg_n;
  logic is_ack, done, got_ack, got_rsd, got_bat_ok, got_bat_err, consumed, fail_evt, abort;
  logic expired, tmo_load, tmo_en;
  logic [TW-1:0] tmo_value;
  assign tmo_load  = state_n != state && state_n inside {INIT_ACK, INIT_BAT, CMD_ACK, ARG_ACK};
  assign tmo_value = state_n == INIT_BAT ? TW'(BAT_TIMEOUT_CYCLES) : TW'(RESP_TIMEOUT_CYCLES);
  assign tmo_en    = is_ack || state == INIT_BAT;
  ps2_timeout_counter #(.W(TW)) u_timeout (
    .clk(clk), .reset(reset), .load(tmo_load), .load_value(tmo_value), .en(tmo_en), .expired(expired)
  );
  always_comb begin
    is_ack = state inside {INIT_ACK, CMD_ACK, ARG_ACK};
    done = send_command && (command_was_sent || command_error);
    got_ack = is_ack && received_data_en && received_data == RSP_ACK;
    got_rsd = is_ack && received_data_en && received_data == RSP_RESEND;
    got_bat_ok = state == INIT_BAT && received_data_en && received_data == RSP_BAT_OK;
    got_bat_err = state == INIT_BAT && received_data_en && received_data == RSP_BAT_ERR;
    consumed = got_ack || got_rsd || got_bat_ok || got_bat_err;
    // error wins over was_sent when the core reports both in one cycle
    fail_evt = (send_command && command_error) || got_rsd || (is_ack && expired && !got_ack);
    // an in-flight byte is never cut off; the abort waits for the core to finish it
    abort = (init_start || init_req) && !(send_command && !done);
    state_n = state;
    retry_n = retry_cnt;
    init_req_n = init_req || init_start;
    led_pend_n = led_pend || led_update;
    led_val_n = led_update ? led_state : led_val;
    typ_pend_n = typ_pend || typematic_update;
    typ_val_n = typematic_update ? typematic_rate & 8'h7F : typ_val;
    cmd_n = cur_cmd;
    arg_n = cur_arg;
    if (abort) begin
      state_n = INIT_SEND;
      retry_n = '0;
      init_req_n = 1'b0;
      led_pend_n = 1'b0;
      typ_pend_n = 1'b0;
    end else if (fail_evt) begin
      state_n = retry_cnt == RW'(MAX_RETRIES) ? FAIL : send_of(state);
      retry_n = retry_cnt + 1'b1;
    end else if (done) begin
      state_n = state == INIT_SEND ? INIT_ACK : state == CMD_SEND ? CMD_ACK : ARG_ACK;
    end else if (got_ack) begin
      state_n = state == INIT_ACK ? INIT_BAT : state == CMD_ACK ? ARG_SEND : READY;
      retry_n = '0;
    end else if (got_bat_ok) begin
      state_n = READY;
    end else if (got_bat_err || (state == INIT_BAT && expired)) begin
      state_n = FAIL;
    end else if (state == READY && led_pend_n) begin
      state_n = CMD_SEND;
      cmd_n = CMD_SET_LEDS;
      arg_n = {5'b0, led_val_n};
      led_pend_n = 1'b0;
      retry_n = '0;
    end else if (state == READY && typ_pend_n) begin
      state_n = CMD_SEND;
      cmd_n = CMD_TYPEMATIC;
      arg_n = typ_val_n;
      typ_pend_n = 1'b0;
      retry_n = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT_SEND;
      retry_cnt <= '0;
      init_req <= 1'b0;
      led_pend <= 1'b0;
      led_val <= '0;
      typ_pend <= 1'b0;
      typ_val <= '0;
      cur_cmd <= '0;
      cur_arg <= '0;
      the_command <= '0;
      send_command <= 1'b0;
      scan_data <= '0;
      scan_valid <= 1'b0;
      busy <= 1'b0;
      kbd_ready <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      retry_cnt <= retry_n;
      init_req <= init_req_n;
      led_pend <= led_pend_n;
      led_val <= led_val_n;
      typ_pend <= typ_pend_n;
      typ_val <= typ_val_n;
      cur_cmd <= cmd_n;
      cur_arg <= arg_n;
      // dropping for one cycle after any completion gives the core a clean request edge
      send_command <= state_n inside {INIT_SEND, CMD_SEND, ARG_SEND} && !done;
      the_command <= state_n == INIT_SEND ? CMD_RESET : state_n == CMD_SEND ? cmd_n :
                     state_n == ARG_SEND ? arg_n : the_command;
      busy <= !(state_n inside {READY, FAIL});
      kbd_ready <= state_n inside {READY, CMD_SEND, CMD_ACK, ARG_SEND, ARG_ACK};
      error <= state_n == FAIL;
      scan_valid <= received_data_en && !consumed;
      if (received_data_en && !consumed) scan_data <= received_data;
    end
  end
endmodule

// File: tb/tb_ps2_command_sequencer.sv
// tb_ps2_command_sequencer: directed scenario bench for ps2_command_sequencer
module tb_ps2_command_sequencer;
  localparam int RESP = 20;
  localparam int BAT = 60;
  logic clk = 0, reset = 1, init_start = 0, led_update = 0, typematic_update = 0;
  logic command_was_sent = 0, command_error = 0, received_data_en = 0;
  logic [2:0] led_state = '0;
  logic [7:0] typematic_rate = '0, received_data = '0;
  logic [7:0] the_command, scan_data;
  logic send_command, scan_valid, busy, kbd_ready, error;
  int checks = 0, errors = 0, rises = 0, scans = 0;
  logic send_prev = 0;
  ps2_command_sequencer #(.RESP_TIMEOUT_CYCLES(RESP), .BAT_TIMEOUT_CYCLES(BAT), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .led_update(led_update), .led_state(led_state),
    .typematic_update(typematic_update), .typematic_rate(typematic_rate), .the_command(the_command),
    .send_command(send_command), .command_was_sent(command_was_sent), .command_error(command_error),
    .received_data(received_data), .received_data_en(received_data_en), .scan_data(scan_data),
    .scan_valid(scan_valid), .busy(busy), .kbd_ready(kbd_ready), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (send_command && !send_prev) rises++;
    send_prev = send_command;
    if (scan_valid) scans++;
  end
  task automatic pulse_led(input logic [2:0] v);
    led_state = v; led_update = 1; @(negedge clk); led_update = 0;
  endtask
  task automatic pulse_typ(input logic [7:0] v);
    typematic_rate = v; typematic_update = 1; @(negedge clk); typematic_update = 0;
  endtask
  task automatic reply(input logic [7:0] b);
    received_data = b; received_data_en = 1; @(negedge clk); received_data_en = 0;
  endtask
  task automatic core_send(input logic err, output logic [7:0] cmd, output int n);
    n = 0;
    while (send_command !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    cmd = send_command === 1'b1 ? the_command : 8'hxx;
    command_was_sent = 1; command_error = err; @(negedge clk); command_was_sent = 0; command_error = 0;
  endtask
  task automatic test_reset;
    reset = 1; repeat (2) @(negedge clk);
    checks++;
    if ({send_command, scan_valid, busy, kbd_ready, error} !== 5'b0 || the_command !== 8'h00 || scan_data !== 8'h00) begin
      errors++; $display("FAIL reset_values: ctl=%b cmd=%h scan=%h, expected 00000 00 00",
                         {send_command, scan_valid, busy, kbd_ready, error}, the_command, scan_data);
    end
    reset = 0; @(negedge clk);
    checks++;
    if (send_command !== 1'b1 || the_command !== 8'hFF || busy !== 1'b1) begin
      errors++; $display("FAIL first_cycle: send=%b cmd=%h busy=%b, expected 1 ff 1", send_command, the_command, busy);
    end
  endtask
  task automatic test_init;
    logic [7:0] c; int n;
    core_send(0, c, n);
    checks++; if (c !== 8'hFF) begin errors++; $display("FAIL init_cmd: got %h expected ff", c); end
    reply(8'hFA); reply(8'hAA); @(negedge clk);
    checks++;
    if (kbd_ready !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL init_ready: ready=%b busy=%b error=%b, expected 1 0 0", kbd_ready, busy, error);
    end
    checks++;
    if (rises !== 1 || scans !== 0) begin errors++; $display("FAIL init_counts: sends=%0d scans=%0d, expected 1 0", rises, scans); end
  endtask
  task automatic test_led;
    logic [7:0] c; int n; int r0 = rises;
    pulse_led(3'b101);
    core_send(0, c, n);
    checks++; if (c !== 8'hED) begin errors++; $display("FAIL led_cmd: got %h expected ed", c); end
    reply(8'hFA);
    core_send(0, c, n);
    checks++; if (c !== 8'h05) begin errors++; $display("FAIL led_arg: got %h expected 05", c); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL led_busy_ack: busy=%b expected 1", busy); end
    reply(8'hFA);
    checks++;
    if (busy !== 1'b0 || rises - r0 !== 2) begin errors++; $display("FAIL led_done: busy=%b sends=%0d, expected 0 2", busy, rises - r0); end
  endtask
  task automatic test_resend;
    logic [7:0] c; int n; int r0 = rises;
    pulse_led(3'b010);
    for (int i = 0; i < 3; i++) begin
      core_send(0, c, n);
      checks++; if (c !== 8'hED) begin errors++; $display("FAIL resend_cmd%0d: got %h expected ed", i, c); end
      reply(i < 2 ? 8'hFE : 8'hFA);
    end
    core_send(0, c, n);
    checks++; if (c !== 8'h02) begin errors++; $display("FAIL resend_arg: got %h expected 02", c); end
    reply(8'hFA);
    checks++;
    if (rises - r0 !== 4 || error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL resend_done: sends=%0d error=%b busy=%b, expected 4 0 0", rises - r0, error, busy);
    end
  endtask
  task automatic test_cmd_error;
    logic [7:0] c; int n; int r0 = rises;
    pulse_typ(8'hFF);
    core_send(1, c, n);
    checks++; if (c !== 8'hF3) begin errors++; $display("FAIL err_cmd: got %h expected f3", c); end
    core_send(0, c, n);
    checks++; if (c !== 8'hF3) begin errors++; $display("FAIL err_resend: got %h expected f3", c); end
    reply(8'hFA);
    core_send(0, c, n);
    checks++; if (c !== 8'h7F) begin errors++; $display("FAIL typ_arg_mask: got %h expected 7f", c); end
    reply(8'hFA);
    checks++;
    if (rises - r0 !== 3 || busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL err_done: sends=%0d busy=%b error=%b, expected 3 0 0", rises - r0, busy, error);
    end
  endtask
  task automatic test_timeout_fail;
    logic [7:0] c; int n; int r0 = rises;
    pulse_typ(8'hAB);
    core_send(0, c, n);
    checks++; if (c !== 8'hF3) begin errors++; $display("FAIL tmo_cmd0: got %h expected f3", c); end
    for (int i = 1; i < 4; i++) begin
      core_send(0, c, n);
      checks++;
      if (c !== 8'hF3 || n < RESP || n > RESP + 2) begin
        errors++; $display("FAIL tmo_resend%0d: cmd=%h gap=%0d, expected f3 gap %0d..%0d", i, c, n, RESP, RESP + 2);
      end
    end
    repeat (RESP + 5) @(negedge clk);
    checks++;
    if (error !== 1'b1 || kbd_ready !== 1'b0 || busy !== 1'b0 || rises - r0 !== 4) begin
      errors++; $display("FAIL tmo_fail: error=%b ready=%b busy=%b sends=%0d, expected 1 0 0 4", error, kbd_ready, busy, rises - r0);
    end
    init_start = 1; @(negedge clk); init_start = 0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reinit_clear: error=%b busy=%b, expected 0 1", error, busy); end
    core_send(0, c, n);
    checks++; if (c !== 8'hFF) begin errors++; $display("FAIL reinit_cmd: got %h expected ff", c); end
    reply(8'hFA); reply(8'hAA); @(negedge clk);
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL reinit_ready: ready=%b expected 1", kbd_ready); end
  endtask
  task automatic test_scan;
    logic [7:0] c; int n; int s0 = scans;
    pulse_led(3'b011);
    core_send(0, c, n);
    checks++; if (c !== 8'hED) begin errors++; $display("FAIL scan_cmd: got %h expected ed", c); end
    reply(8'hFA);
    core_send(0, c, n);
    checks++; if (c !== 8'h03) begin errors++; $display("FAIL scan_arg: got %h expected 03", c); end
    reply(8'h1C);
    checks++;
    if (scan_valid !== 1'b1 || scan_data !== 8'h1C) begin
      errors++; $display("FAIL scan_fwd: valid=%b data=%h, expected 1 1c", scan_valid, scan_data);
    end
    @(negedge clk);
    checks++;
    if (scan_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL scan_pulse: valid=%b busy=%b, expected 0 1", scan_valid, busy); end
    reply(8'hFA); @(negedge clk);
    checks++;
    if (busy !== 1'b0 || scans - s0 !== 1) begin errors++; $display("FAIL scan_ack: busy=%b scans=%0d, expected 0 1", busy, scans - s0); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] c; int n; int r0 = rises;
    pulse_led(3'b100);
    core_send(0, c, n);
    checks++; if (c !== 8'hED) begin errors++; $display("FAIL b2b_cmd1: got %h expected ed", c); end
    pulse_led(3'b001);
    reply(8'hFA);
    pulse_led(3'b110);
    core_send(0, c, n);
    checks++; if (c !== 8'h04) begin errors++; $display("FAIL b2b_arg1: got %h expected 04", c); end
    reply(8'hFA);
    core_send(0, c, n);
    checks++; if (c !== 8'hED) begin errors++; $display("FAIL b2b_cmd2: got %h expected ed", c); end
    reply(8'hFA);
    core_send(0, c, n);
    checks++; if (c !== 8'h06) begin errors++; $display("FAIL b2b_arg2: got %h expected 06", c); end
    reply(8'hFA);
    repeat (10) @(negedge clk);
    checks++;
    if (rises - r0 !== 4 || busy !== 1'b0) begin errors++; $display("FAIL b2b_count: sends=%0d busy=%b, expected 4 0", rises - r0, busy); end
  endtask
  task automatic test_async_reset;
    logic [7:0] c; int n;
    pulse_led(3'b111);
    #3 reset = 1;
    #1;
    checks++;
    if (send_command !== 1'b0 || busy !== 1'b0 || kbd_ready !== 1'b0 || the_command !== 8'h00) begin
      errors++; $display("FAIL async_reset: send=%b busy=%b ready=%b cmd=%h, expected 0 0 0 00", send_command, busy, kbd_ready, the_command);
    end
    @(negedge clk); reset = 0;
    core_send(0, c, n);
    checks++; if (c !== 8'hFF) begin errors++; $display("FAIL async_reinit_cmd: got %h expected ff", c); end
    reply(8'hFA); reply(8'hAA); @(negedge clk);
    checks++;
    if (kbd_ready !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL async_reinit_ready: ready=%b error=%b, expected 1 0", kbd_ready, error); end
  endtask
  initial begin
    test_reset;
    test_init;
    test_led;
    test_resend;
    test_cmd_error;
    test_timeout_fail;
    test_scan;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_command_sequencer.md
# ps2_command_sequencer

Host-side controller that sequences the PS/2 serial core (command byte out, received byte in) for a keyboard. After reset it runs the keyboard init handshake (reset command, ACK, self-test result), then serves LED-update and typematic-rate requests as two-byte command transactions with ACK checking, resend, timeout and retry. Received bytes that are not command responses are forwarded as scan data to the downstream FIFO/Avalon wrapper.

## Interface
- RESP_TIMEOUT_CYCLES, 2_500_000, max cycles to wait for an ACK or resend byte (50 ms @ 50 MHz)
- BAT_TIMEOUT_CYCLES, 50_000_000, max cycles to wait for the self-test result after reset ACK (1 s @ 50 MHz)
- MAX_RETRIES, 3, resend attempts per byte before declaring failure

- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high
- init_start  in  1  pulse: re-run init sequence; clears error
- led_update  in  1  pulse: send LED command using led_state
- led_state  in  3  {caps, num, scroll} sampled when led_update=1
- typematic_update  in  1  pulse: send typematic command using typematic_rate
- typematic_rate  in  8  rate/delay byte sampled when typematic_update=1
- the_command  out  8  byte to PS/2 core
- send_command  out  1  level request to PS/2 core
- command_was_sent  in  1  core: byte transmitted
- command_error  in  1  core: transmit timed out
- received_data  in  8  core: received byte
- received_data_en  in  1  core: received byte valid (1 cycle)
- scan_data  out  8  forwarded byte
- scan_valid  out  1  1-cycle strobe for scan_data
- busy  out  1  a transaction is in progress
- kbd_ready  out  1  init succeeded, no failure since
- error  out  1  sticky failure flag

## Operation
- States: INIT_SEND, INIT_ACK, INIT_BAT, READY, CMD_SEND, CMD_ACK, ARG_SEND, ARG_ACK, FAIL.
- Reset → INIT_SEND. INIT_SEND sends 0xFF → INIT_ACK. 0xFA → INIT_BAT; 0xFE or timeout → retry.
- INIT_BAT: 0xAA → READY, kbd_ready=1; 0xFC or BAT timeout → FAIL.
- READY: service in priority init_start > LED > typematic. LED: CMD byte 0xED, ARG {5'b0, led_state}. Typematic: 0xF3, ARG typematic_rate & 0x7F.
- CMD_SEND → CMD_ACK (0xFA) → ARG_SEND → ARG_ACK (0xFA) → READY.
- *_SEND: the_command stable, send_command=1 until command_was_sent (→ matching *_ACK) or command_error (→ retry same byte).
- Retry: resend current byte, retry counter +1; counter cleared on each accepted ACK. Counter reaching MAX_RETRIES with another failure → FAIL.
- FAIL: error=1, kbd_ready=0, busy=0; leaves only on init_start (→ INIT_SEND, error cleared).
- Pending: led_update/typematic_update while busy set a pending flag and latch the value; the latest request wins; one transaction per flag. Flags are cleared when their transaction reaches CMD_SEND. init_start in any state aborts the current transaction at the next send boundary (immediately if in an *_ACK/FAIL/READY state), deasserts send_command and clears the pending flags.
- Byte consumption: in *_ACK states 0xFA/0xFE are consumed; in INIT_BAT 0xAA/0xFC are consumed. Any other byte in any state is forwarded.
- Timeout counter: width $clog2(BAT_TIMEOUT_CYCLES+1). Reloads on entry to each *_ACK/INIT_BAT state and freezes in other states.

## Timing
- Reset values: the_command=0x00, send_command=0, scan_data=0x00, scan_valid=0, busy=0, kbd_ready=0, error=0, all counters and flags 0.
- The first cycle after reset deasserts: state INIT_SEND, send_command=1, the_command=0xFF; busy=1 from the same cycle.
- All outputs are registered. scan_valid pulses exactly 1 cycle, 1 cycle after received_data_en.
- Response evaluation: received_data_en at cycle N → next state at N+1.
- Next *_SEND is entered the cycle after an ACK is accepted. send_command reasserts at the earliest 1 cycle after a completion (minimum 1 low cycle).
- Timeout fires when the counter reaches its limit: exactly RESP_TIMEOUT_CYCLES (or BAT_TIMEOUT_CYCLES) cycles after state entry without a response.
- command_was_sent and command_error asserted in the same cycle: treat as error.
- ACK and a request arriving in the same cycle: the request is latched as pending; no loss.
- Asynchronous reset mid-transaction: outputs go to reset values immediately, then init restarts.

## Structure
- Package ps2_pkg: command constants (0xFF reset, 0xED LEDs, 0xF3 typematic), response constants (0xFA, 0xFE, 0xAA, 0xFC) and the state enum.
- One natural sub-module: ps2_timeout_counter (load value, enable, expired flag). Everything else stays in one FSM module.

## Test plan
- Reset; model responds 0xFA then 0xAA → sends 0xFF once; kbd_ready=1, busy=0 in READY; no scan_valid.
- In READY, led_update with led_state=3'b101, model ACKs both bytes → the_command 0xED then 0x05; busy drops 1 cycle after the second 0xFA.
- Model answers 0xED with 0xFE twice, then 0xFA → 0xED sent 3 times; transaction completes; error=0.
- Model silent after 0xF3 (MAX_RETRIES=3) → 4 sends, each separated by RESP_TIMEOUT_CYCLES; then FAIL with error=1, kbd_ready=0; init_start restarts at 0xFF.
- Scan byte 0x1C during ARG_ACK, then 0xFA → scan_valid with 0x1C; ACK consumed; sequence completes.
- led_update twice while busy (3'b001 then 3'b110) → exactly one further LED transaction, with arg 0x06.
